// File: rtl/uart_reg_pkg.sv
// rtl/uart_reg_pkg.sv - UART register map, FR bits, result codes and initiator FSM encoding
package uart_reg_pkg;

    localparam logic [3:0] ADDR_LCR  = 4'h1;
    localparam logic [3:0] ADDR_FCR  = 4'h2;
    localparam logic [3:0] ADDR_CR   = 4'h3;
    localparam logic [3:0] ADDR_FR   = 4'h4;
    localparam logic [3:0] ADDR_IBRD = 4'h7;
    localparam logic [3:0] ADDR_FBRD = 4'h8;

    localparam int FR_TXFF = 7;
    localparam int FR_TXFE = 6;
    localparam int FR_RXFF = 5;
    localparam int FR_RXFE = 4;
    localparam int FR_OE   = 2;
    localparam int FR_FE   = 1;
    localparam int FR_PE   = 0;

    localparam logic [1:0] RES_OK      = 2'b00;
    localparam logic [1:0] RES_VERIFY  = 2'b01;
    localparam logic [1:0] RES_TIMEOUT = 2'b10;

    localparam logic [2:0] LAST_STEP = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_GAP,
        ST_RD,
        ST_RD_CAP,
        ST_POLL,
        ST_POLL_CAP,
        ST_FIN
    } state_t;

    // Step 0 disables the UART (CR); steps 1..5 double as the verify order.
    function automatic logic [3:0] step_addr(input logic [2:0] step);
        logic [3:0] a;
        case (step)
            3'd1:    a = ADDR_IBRD;
            3'd2:    a = ADDR_FBRD;
            3'd3:    a = ADDR_LCR;
            3'd4:    a = ADDR_FCR;
            default: a = ADDR_CR;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/uart_dsp_init.sv
// rtl/uart_dsp_init.sv - DSP-bus initiator: programs the UART, verifies it, then polls FR
module uart_dsp_init
    import uart_reg_pkg::*;
#(
    parameter bit          VERIFY_EN  = 1'b1,
    parameter logic [15:0] POLL_MASK  = 16'h0040,
    parameter logic [15:0] POLL_MATCH = 16'h0040,
    parameter logic [7:0]  POLL_MAX   = 8'd200
) (
    input  logic        DSP_CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [15:0] LCR_VAL,
    input  logic [15:0] FCR_VAL,
    input  logic [15:0] CR_VAL,
    input  logic [15:0] IBRD_VAL,
    input  logic [15:0] FBRD_VAL,
    output logic        DSP_CEn,
    output logic        DSP_WEn,
    output logic [3:0]  DSP_ADDR,
    output logic [15:0] DSP_WDATA,
    input  logic [15:0] DSP_RDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [1:0]  RESULT,
    output logic [3:0]  ERR_ADDR,
    output logic [15:0] STATUS
);

    state_t      state_q;
    logic [2:0]  step_q;
    logic [7:0]  poll_cnt_q;
    logic [15:0] lcr_q, fcr_q, cr_q, ibrd_q, fbrd_q;

    logic [2:0]  step_d;
    logic [15:0] val_d;
    logic [15:0] val_cur;
    logic [7:0]  poll_cnt_d;
    logic        poll_hit;

    function automatic logic [15:0] step_val(input logic [2:0] s);
        logic [15:0] v;
        case (s)
            3'd1:    v = ibrd_q;
            3'd2:    v = fbrd_q;
            3'd3:    v = lcr_q;
            3'd4:    v = fcr_q;
            3'd5:    v = cr_q;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    assign step_d     = step_q + 3'd1;
    assign val_d      = step_val(step_d);
    assign val_cur    = step_val(step_q);
    assign poll_hit   = ((DSP_RDATA & POLL_MASK) == POLL_MATCH);
    assign poll_cnt_d = (poll_cnt_q == 8'hFF) ? poll_cnt_q : poll_cnt_q + 8'd1;

    // Bus outputs default to the idle/gap value each cycle; only access-issuing transitions pull CEn low.
    always_ff @(posedge DSP_CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            step_q     <= 3'd0;
            poll_cnt_q <= 8'd0;
            lcr_q      <= 16'h0000;
            fcr_q      <= 16'h0000;
            cr_q       <= 16'h0000;
            ibrd_q     <= 16'h0000;
            fbrd_q     <= 16'h0000;
            DSP_CEn    <= 1'b1;
            DSP_WEn    <= 1'b1;
            DSP_ADDR   <= 4'h0;
            DSP_WDATA  <= 16'h0000;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            RESULT     <= RES_OK;
            ERR_ADDR   <= 4'h0;
            STATUS     <= 16'h0000;
        end else begin
            DSP_CEn <= 1'b1;
            DSP_WEn <= 1'b1;
            DONE    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        lcr_q      <= LCR_VAL;
                        fcr_q      <= FCR_VAL;
                        cr_q       <= CR_VAL;
                        ibrd_q     <= IBRD_VAL;
                        fbrd_q     <= FBRD_VAL;
                        RESULT     <= RES_OK;
                        ERR_ADDR   <= 4'h0;
                        STATUS     <= 16'h0000;
                        poll_cnt_q <= 8'd0;
                        step_q     <= 3'd0;
                        BUSY       <= 1'b1;
                        DSP_CEn    <= 1'b0;
                        DSP_WEn    <= 1'b0;
                        DSP_ADDR   <= ADDR_CR;
                        DSP_WDATA  <= 16'h0000;
                        state_q    <= ST_WR;
                    end
                end
                ST_WR: state_q <= ST_WR_GAP;
                ST_WR_GAP: begin
                    if (step_q != LAST_STEP) begin
                        step_q    <= step_d;
                        DSP_CEn   <= 1'b0;
                        DSP_WEn   <= 1'b0;
                        DSP_ADDR  <= step_addr(step_d);
                        DSP_WDATA <= val_d;
                        state_q   <= ST_WR;
                    end else if (VERIFY_EN) begin
                        step_q   <= 3'd1;
                        DSP_CEn  <= 1'b0;
                        DSP_ADDR <= step_addr(3'd1);
                        state_q  <= ST_RD;
                    end else begin
                        DSP_CEn  <= 1'b0;
                        DSP_ADDR <= ADDR_FR;
                        state_q  <= ST_POLL;
                    end
                end
                ST_RD: state_q <= ST_RD_CAP;
                ST_RD_CAP: begin
                    if (DSP_RDATA != val_cur) begin
                        RESULT   <= RES_VERIFY;
                        ERR_ADDR <= step_addr(step_q);
                        DONE     <= 1'b1;
                        state_q  <= ST_FIN;
                    end else if (step_q != LAST_STEP) begin
                        step_q   <= step_d;
                        DSP_CEn  <= 1'b0;
                        DSP_ADDR <= step_addr(step_d);
                        state_q  <= ST_RD;
                    end else begin
                        DSP_CEn  <= 1'b0;
                        DSP_ADDR <= ADDR_FR;
                        state_q  <= ST_POLL;
                    end
                end
                ST_POLL: state_q <= ST_POLL_CAP;
                ST_POLL_CAP: begin
                    STATUS     <= DSP_RDATA;
                    poll_cnt_q <= poll_cnt_d;
                    if (poll_hit) begin
                        RESULT  <= RES_OK;
                        DONE    <= 1'b1;
                        state_q <= ST_FIN;
                    end else if (poll_cnt_d == POLL_MAX) begin
                        RESULT  <= RES_TIMEOUT;
                        DONE    <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        DSP_CEn  <= 1'b0;
                        DSP_ADDR <= ADDR_FR;
                        state_q  <= ST_POLL;
                    end
                end
                ST_FIN: begin
                    BUSY    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_dsp_init.md
Name: uart_dsp_init

Overview:
- DSP-bus initiator that drives the UART register block's DSP slave port (DSP_CEn/DSP_WEn/DSP_ADDR/DSP_WDATA/DSP_RDATA).
- On START it runs a fixed programming sequence, then optionally reads back and verifies each register.
- It then polls the flag register FR until a masked condition matches or a poll limit expires.
- Sits beside the UART in place of DSP software for autonomous bring-up.

Parameters:
- VERIFY_EN, 1, 1 = run the read-back verify phase; 0 = skip it.
- POLL_MASK, 16'h0040, FR bits examined; default is TxFIFO_Empty.
- POLL_MATCH, 16'h0040, required value of FR & POLL_MASK.
- POLL_MAX, 200, maximum FR polls before timeout (1..255).

Ports:
- DSP_CLK  in  1  single clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request; ignored while BUSY.
- LCR_VAL  in  16  LCR value (addr 4'h1).
- FCR_VAL  in  16  FCR value (addr 4'h2).
- CR_VAL  in  16  CR value (addr 4'h3).
- IBRD_VAL  in  16  IBRD value (addr 4'h7).
- FBRD_VAL  in  16  FBRD value (addr 4'h8).
- DSP_CEn  out  1  chip enable, active low, registered.
- DSP_WEn  out  1  0 = write, 1 = read, registered.
- DSP_ADDR  out  4  register address [4:1], registered.
- DSP_WDATA  out  16  write data, registered.
- DSP_RDATA  in  16  read data; valid the cycle after the read cycle.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  2  00 = ok, 01 = verify fail, 10 = poll timeout; held until next START.
- ERR_ADDR  out  4  address of the first verify mismatch, else 0.
- STATUS  out  16  last captured FR value.

Behaviour:
- Reset (synchronous, RESET=1 at an edge):
  - Output values: DSP_CEn=1, DSP_WEn=1, DSP_ADDR=0, DSP_WDATA=0, BUSY=0, DONE=0, RESULT=00, ERR_ADDR=0, STATUS=0.
  - FSM goes to IDLE and the poll counter clears.
  - Reset mid-sequence aborts it; the bus is idle (CEn=1) from the next cycle. No partial-completion DONE is issued.
- Latching: *_VAL inputs are latched on the START edge and are stable for the whole run. START clears RESULT, ERR_ADDR and STATUS.
- Bus access rule: every access is one active cycle (CEn=0) followed by one gap cycle (CEn=1, WEn=1), so each access takes 2 cycles.
  - Write: CEn=0, WEn=0, ADDR/WDATA valid for one cycle.
  - Read: CEn=0, WEn=1, ADDR valid; DSP_RDATA is captured at the end of the gap cycle.
- FSM states: IDLE, WR, WR_GAP, RD, RD_CAP, POLL, POLL_CAP, FIN.
  - IDLE -> WR on START.
  - Write order, step 0..5: CR<=0, IBRD, FBRD, LCR, FCR, CR<=CR_VAL. Disabling first prevents the UART running on half-programmed settings.
  - After step 5: go to RD if VERIFY_EN, else POLL.
  - Verify order: IBRD, FBRD, LCR, FCR, CR. Each capture is compared, all 16 bits, against the latched value.
  - First mismatch: RESULT=01, ERR_ADDR=that address, go to FIN (no poll).
  - POLL: read addr 4'h4 and capture into STATUS. If (STATUS & POLL_MASK)==POLL_MATCH then RESULT=00 -> FIN.
  - Else increment the poll count. If count==POLL_MAX then RESULT=10 -> FIN, else re-issue POLL.
  - FIN: DONE=1 for one cycle -> IDLE.
- Timing: the START edge is E0, and cycle 1 is the first write.
  - VERIFY_EN=1 with first-poll match: writes occupy cycles 1-12, verify 13-22, poll 23-24, DONE in cycle 25.
  - VERIFY_EN=0: poll 13-14, DONE in cycle 15.
  - BUSY is high from cycle 1 through the DONE cycle inclusive.
- START while BUSY, including during FIN: ignored, and it is not queued.
- START and RESET in the same cycle: reset wins.
- Poll counter is 8 bits and saturates; it never wraps.

Decomposition:
- Shared package uart_reg_pkg:
  - Address constants ADDR_LCR=4'h1, ADDR_FCR=4'h2, ADDR_CR=4'h3, ADDR_FR=4'h4, ADDR_IBRD=4'h7, ADDR_FBRD=4'h8.
  - FR bit indices: 7 TxFull, 6 TxEmpty, 5 RxFull, 4 RxEmpty, 2 Overrun, 1 Frame, 0 Parity.
  - RESULT code constants and the FSM state encoding.
- Optional single sub-module: uart_dsp_bus_if.
  - Two-cycle access engine: req/we/addr/wdata in, ack/rdata out.
  - The top-level FSM sequences it.

Test Plan:
1. Behavioural slave model, TxEmpty=1. START with LCR=16'h0033, FCR=16'h0044, CR=16'h0007, IBRD=16'h001A, FBRD=16'h0003.
   -> Bus sees writes to 3, 7, 8, 1, 2, 3 with data 0000, 001A, 0003, 0033, 0044, 0007, then reads 7, 8, 1, 2, 3, then 4.
   -> DONE in cycle 25, RESULT=00, STATUS=16'h0050 (TxEmpty, RxEmpty).
2. Slave FBRD bit 0 stuck at 0, FBRD_VAL=16'h0003.
   -> RESULT=01, ERR_ADDR=4'h8, no FR read issued, DONE in cycle 17.
3. POLL_MAX=3, slave TxEmpty=0.
   -> Exactly 3 FR reads, RESULT=10, DONE one cycle after the third capture.
4. TxEmpty rises after the 2nd poll.
   -> Exactly 3 polls, RESULT=00, STATUS[6]=1.
5. START pulsed in cycle 5 of a run.
   -> No effect: same single DONE, same bus trace as scenario 1.
6. RESET asserted in cycle 8.
   -> Next cycle CEn=1 and BUSY=0, no DONE, RESULT=00.
   -> A new START then runs the full sequence correctly.
7. VERIFY_EN=0, scenario 1 values.
   -> No reads of 7, 8, 1, 2, 3; FR read in cycles 13-14; DONE in cycle 15.
